// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared types and per-boundary width defaults for pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int DEFAULT_CTRL_W = 8;
  localparam int DEFAULT_DATA_W = 64;

  // Per-boundary widths: control carries wb_en/mem_r_en/mem_w_en/b/s etc.
  localparam int IF_ID_CTRL_W   = 1;
  localparam int IF_ID_DATA_W   = 64;
  localparam int ID_EXE_CTRL_W  = 8;
  localparam int ID_EXE_DATA_W  = 160;
  localparam int EXE_MEM_CTRL_W = 4;
  localparam int EXE_MEM_DATA_W = 96;
  localparam int MEM_WB_CTRL_W  = 2;
  localparam int MEM_WB_DATA_W  = 69;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle of one pipeline stage register
interface pipe_stage_reg_if #(
  parameter int CTRL_W = pipe_pkg::DEFAULT_CTRL_W,
  parameter int DATA_W = pipe_pkg::DEFAULT_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Surrounding pipeline: produces the upstream beat and the downstream ready.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // The stage register itself.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// rtl/pipe_stage_reg_slot.sv - one {valid, ctrl, data} entry with load and clear
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load so an emptied entry never carries stale fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic inter-stage register with handshake, optional skid entry and flush-kill counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_kills
);

  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;

  occ_t              w_state;
  logic [1:0]        w_occ;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_consume;
  logic [CNT_W:0]    w_kill_sum;
  logic [CNT_W-1:0]  r_flush_kills;

  // The skid entry is only ever filled behind a full main entry, so the slot
  // valids encode the occupancy directly.
  assign w_state = w_skid_valid ? TWO : (w_main_valid ? ONE : EMPTY);
  assign w_occ   = w_state;

  assign w_out_valid = ~freeze & w_main_valid;
  assign w_in_ready  = (SKID != 0) ? (~freeze & (w_state != TWO))
                                   : (~freeze & (~w_main_valid | bus.out_ready));
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_consume   = w_out_valid & bus.out_ready;

  // Next-entry control: flush clears everything, otherwise walk the occupancy FSM.
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (w_state)
        EMPTY: w_main_load = w_accept;
        ONE: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept && (SKID != 0)) begin
            w_skid_load = 1'b1;
          end else if (w_consume) begin
            w_main_clear = 1'b1;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : bus.in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : bus.in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_in),
    .i_data  (w_main_data_in),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (bus.in_ctrl),
        .i_data  (bus.in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
    end
  endgenerate

  // One spare bit catches overflow so the count can pin at all-ones.
  assign w_kill_sum = {1'b0, r_flush_kills} + (CNT_W+1)'(w_occ);

  // Add the pre-flush occupancy on every flush, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_kills <= '0;
    end else if (flush) begin
      r_flush_kills <= w_kill_sum[CNT_W] ? {CNT_W{1'b1}} : w_kill_sum[CNT_W-1:0];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_valid ? w_main_ctrl : '0;
  assign bus.out_data  = w_main_data;
  assign occupancy     = w_occ;
  assign flush_kills   = r_flush_kills;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in skid, small-counter and single-entry configurations
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) if_a ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) if_b ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(64)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_ctrl = in_ctrl;
  assign if_a.in_data  = in_data;   assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.in_ctrl = in_ctrl;
  assign if_b.in_data  = in_data;   assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.in_ctrl = in_ctrl;
  assign if_c.in_data  = in_data;   assign if_c.out_ready = out_ready;

  logic [1:0]  occ_a, occ_b, occ_c;
  logic [15:0] fk_a, fk_c;
  logic [1:0]  fk_b;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .bus(if_a.slave),
    .occupancy(occ_a), .flush_kills(fk_a));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .bus(if_b.slave),
    .occupancy(occ_b), .flush_kills(fk_b));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .bus(if_c.slave),
    .occupancy(occ_c), .flush_kills(fk_c));

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // FIFO model: each instance is a bounded queue of {ctrl,data} plus a kill tally.
  bit          m_skid[3] = '{1'b1, 1'b1, 1'b0};
  int          m_kmax[3] = '{65535, 3, 65535};
  logic [71:0] m_e[3][2];
  int          m_n[3] = '{0, 0, 0};
  int          m_k[3] = '{0, 0, 0};

  function automatic int exp_n(input int i);
    return rst ? 0 : m_n[i];
  endfunction
  function automatic bit exp_rdy(input int i);
    if (freeze) return 1'b0;
    if (m_skid[i]) return exp_n(i) < 2;
    return (exp_n(i) == 0) || out_ready;
  endfunction
  function automatic bit exp_ov(input int i);
    return !freeze && (exp_n(i) > 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit acc;
      bit con;
      acc = in_valid && exp_rdy(i);
      con = exp_ov(i) && out_ready;
      if (rst) begin
        m_n[i] = 0;
        m_k[i] = 0;
      end else if (flush) begin
        m_k[i] = (m_k[i] + m_n[i] > m_kmax[i]) ? m_kmax[i] : m_k[i] + m_n[i];
        m_n[i] = 0;
      end else begin
        if (con) begin
          m_e[i][0] = m_e[i][1];
          m_n[i] = m_n[i] - 1;
        end
        if (acc) begin
          m_e[i][m_n[i]] = {in_ctrl, in_data};
          m_n[i] = m_n[i] + 1;
        end
      end
    end
  end

  task automatic check_dut(input string tag, input int i, input logic ov, input logic ir,
                           input logic [7:0] oc, input logic [63:0] od,
                           input logic [1:0] occ, input logic [15:0] fk);
    logic [71:0] head;
    head = m_e[i][0];
    chk({tag, ".out_valid"}, 72'(ov), 72'(exp_ov(i)));
    chk({tag, ".in_ready"}, 72'(ir), 72'(exp_rdy(i)));
    chk({tag, ".out_ctrl"}, 72'(oc), exp_ov(i) ? 72'(head[71:64]) : 72'd0);
    chk({tag, ".out_data"}, 72'(od), (exp_n(i) > 0) ? 72'(head[63:0]) : 72'd0);
    chk({tag, ".occupancy"}, 72'(occ), 72'(exp_n(i)));
    chk({tag, ".flush_kills"}, 72'(fk), rst ? 72'd0 : 72'(m_k[i]));
  endtask

  logic [63:0] log_a[$];

  always @(negedge clk) begin
    check_dut("a", 0, if_a.out_valid, if_a.in_ready, if_a.out_ctrl, if_a.out_data, occ_a, fk_a);
    check_dut("b", 1, if_b.out_valid, if_b.in_ready, if_b.out_ctrl, if_b.out_data, occ_b, {14'd0, fk_b});
    check_dut("c", 2, if_c.out_valid, if_c.in_ready, if_c.out_ctrl, if_c.out_data, occ_c, fk_c);
    if (if_a.out_valid && out_ready) log_a.push_back(if_a.out_data);
  end

  task automatic drive(input bit v, input logic [63:0] d, input bit ordy,
                       input bit fl = 1'b0, input bit fz = 1'b0);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = d[7:0] ^ 8'h5A;
    out_ready = ordy;
    flush     = fl;
    freeze    = fz;
  endtask

  logic [63:0] want_log[10] = '{64'h1, 64'h2, 64'h3, 64'h4, 64'hA, 64'hB, 64'hC, 64'hD, 64'h77, 64'h78};

  initial begin
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst = 1'b0;
    #1;
    chk("reset.occupancy", 72'(occ_a), 72'd0);
    chk("reset.out_valid", 72'(if_a.out_valid), 72'd0);
    chk("reset.flush_kills", 72'(fk_a), 72'd0);
    chk("reset.in_ready", 72'(if_a.in_ready), 72'd1);

    // back-to-back stream at full throughput
    drive(1, 64'h1, 1);
    drive(1, 64'h2, 1);
    #1;
    chk("stream.occ_one", 72'(occ_a), 72'd1);
    chk("stream.first_data", 72'(if_a.out_data), 72'h1);
    chk("stream.first_ctrl", 72'(if_a.out_ctrl), 72'h5B);
    drive(1, 64'h3, 1);
    drive(1, 64'h4, 1);
    drive(0, 0, 1);
    #1;
    chk("stream.last_data", 72'(if_a.out_data), 72'h4);
    drive(0, 0, 1);

    // downstream stall absorbed by the skid entry
    drive(1, 64'hA, 0);
    drive(1, 64'hB, 0);
    drive(1, 64'hC, 0);
    #1;
    chk("skid.occ_two", 72'(occ_a), 72'd2);
    chk("skid.in_ready_low", 72'(if_a.in_ready), 72'd0);
    drive(1, 64'hC, 0);
    drive(1, 64'hC, 1);
    drive(1, 64'hC, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // freeze holds a single entry
    drive(1, 64'hD, 0);
    for (int k = 0; k < 3; k++) drive(1, 64'hE, 0, 0, 1);
    #1;
    chk("freeze.out_valid", 72'(if_a.out_valid), 72'd0);
    chk("freeze.in_ready", 72'(if_a.in_ready), 72'd0);
    chk("freeze.out_data", 72'(if_a.out_data), 72'hD);
    chk("freeze.occupancy", 72'(occ_a), 72'd1);
    chk("freeze.out_ctrl", 72'(if_a.out_ctrl), 72'd0);
    drive(0, 0, 1);
    #1;
    chk("freeze.release", 72'(if_a.out_valid), 72'd1);
    drive(0, 0, 1);

    // flush at occupancy 2 with a beat offered and freeze also high
    drive(1, 64'hF, 0);
    drive(1, 64'h10, 0);
    drive(1, 64'h48, 0, 1, 1);
    drive(0, 0, 0);
    #1;
    chk("flush.occupancy", 72'(occ_a), 72'd0);
    chk("flush.out_ctrl", 72'(if_a.out_ctrl), 72'd0);
    chk("flush.out_data", 72'(if_a.out_data), 72'd0);
    chk("flush.kills_a", 72'(fk_a), 72'd2);
    chk("flush.kills_c", 72'(fk_c), 72'd1);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // counter saturation on the 2-bit instance
    for (int k = 0; k < 4; k++) begin
      drive(1, 64'h20 + 64'(k), 0);
      drive(0, 0, 0, 1);
    end
    drive(0, 0, 0);
    #1;
    chk("sat.kills_b", 72'(fk_b), 72'd3);
    chk("sat.kills_a", 72'(fk_a), 72'd6);

    // single-entry ready follows out_ready combinationally
    drive(1, 64'h77, 0);
    drive(1, 64'h78, 0);
    #1;
    chk("noskid.out_valid", 72'(if_c.out_valid), 72'd1);
    chk("noskid.in_ready_low", 72'(if_c.in_ready), 72'd0);
    out_ready = 1'b1;
    #1;
    chk("noskid.in_ready_high", 72'(if_c.in_ready), 72'd1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // asynchronous reset mid-operation
    drive(1, 64'h99, 0);
    drive(0, 0, 0);
    #1;
    chk("areset.pre_occ", 72'(occ_a), 72'd1);
    rst = 1'b1;
    #1;
    chk("areset.occupancy", 72'(occ_a), 72'd0);
    chk("areset.out_valid", 72'(if_a.out_valid), 72'd0);
    chk("areset.kills", 72'(fk_a), 72'd0);
    drive(0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 1);
    drive(0, 0, 1);

    chk("order.count", 72'(log_a.size()), 72'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < log_a.size()) chk($sformatf("order.beat%0d", k), 72'(log_a[k]), 72'(want_log[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
